// File: rtl/md5_pkg.sv
// Shared constants for the MD5/SHA streaming padder and its length-field helpers.
// The states are plain localparams so legacy blocks can compare against them directly.
package md5_pkg;

  localparam int unsigned BlockBits  = 512;
  localparam int unsigned BlockBytes = BlockBits / 8;
  localparam int unsigned LenOffset  = 56;
  localparam int unsigned LenBitPos  = LenOffset * 8;
  localparam logic [7:0]  PadMarker  = 8'h80;

  // Padder FSM encoding
  localparam logic [0:0] StFill = 1'b0;
  localparam logic [0:0] StOut  = 1'b1;

endpackage

// File: rtl/md5_len_field.sv
// Converts a 64-bit message bit count into the 8-byte length field of a padded block.
// LEN_LE=1 places len[7:0] in the first field byte (MD5); LEN_LE=0 in the last (SHA).
module md5_len_field #(
  parameter bit LEN_LE = 1'b1
) (
  input  logic [63:0] len_i,
  output logic [0:63] field_o
);

  always_comb begin
    field_o = '0;
    for (int k = 0; k < 8; k++) begin
      if (LEN_LE) begin
        field_o[8*k +: 8] = len_i[8*k +: 8];
      end else begin
        field_o[8*k +: 8] = len_i[8*(7-k) +: 8];
      end
    end
  end

endmodule

// File: rtl/md5_stream_padder.sv
// Streaming message padder: packs byte beats into 512-bit blocks, appends the 0x80 marker,
// zero fill and 64-bit bit length, spilling into an extra block when the tail does not fit.
module md5_stream_padder
  import md5_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter bit          LEN_LE     = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [0:8*WORD_BYTES-1]           in_data,
  input  logic                              in_last,
  input  logic [$clog2(WORD_BYTES+1)-1:0]   in_nbytes,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [0:BlockBits-1]              out_block,
  output logic                              out_first,
  output logic                              out_last
);

  logic [0:0]           state_q, state_d;
  logic [5:0]           ptr_q, ptr_d;
  logic [63:0]          len_q, len_d;
  logic                 first_q, first_d;
  logic                 ext_q, ext_d;
  logic                 mark_q, mark_d;
  logic                 last_q, last_d;
  logic                 ofirst_q, ofirst_d;
  logic [0:BlockBits-1] blk_q, blk_d;
  logic                 run_q;

  logic        beat_acc, blk_acc;
  logic [6:0]  nb_eff;
  logic [6:0]  end_ptr;
  logic        full_blk;
  logic [63:0] len_wr;
  logic [63:0] len_src;
  logic [0:63] len_field;

  // run_q keeps in_ready low until the first clock edge after reset release
  assign in_ready  = run_q && (state_q == StFill);
  assign out_valid = (state_q == StOut);
  assign out_block = blk_q;
  assign out_first = ofirst_q;
  assign out_last  = last_q;

  assign beat_acc = in_valid && in_ready;
  assign blk_acc  = out_valid && out_ready;

  always_comb begin
    nb_eff = 7'(WORD_BYTES);
    if (in_last && (32'(in_nbytes) < WORD_BYTES)) begin
      nb_eff = 7'(in_nbytes);
    end
  end

  assign end_ptr  = {1'b0, ptr_q} + nb_eff;
  assign full_blk = (ptr_q == 6'(BlockBytes - WORD_BYTES));
  assign len_wr   = len_q + {54'd0, nb_eff, 3'b000};

  // In FILL the field must already include the closing beat; in OUT len_q is final.
  assign len_src = (state_q == StOut) ? len_q : len_wr;

  md5_len_field #(
    .LEN_LE (LEN_LE)
  ) u_len_field (
    .len_i   (len_src),
    .field_o (len_field)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    first_d  = first_q;
    ext_d    = ext_q;
    mark_d   = mark_q;
    last_d   = last_q;
    ofirst_d = ofirst_q;
    blk_d    = blk_q;

    case (state_q)
      StFill: begin
        if (beat_acc) begin
          len_d = len_wr;
          if (in_last) begin
            for (int i = 0; i < int'(BlockBytes); i++) begin
              if (7'(i) >= end_ptr) begin
                blk_d[8*i +: 8] = 8'h00;
              end
            end
            for (int k = 0; k < int'(WORD_BYTES); k++) begin
              if (7'(k) < nb_eff) begin
                blk_d[{ptr_q + 6'(k), 3'b000} +: 8] = in_data[8*k +: 8];
              end
            end
            if (end_ptr < 7'd64) begin
              blk_d[{end_ptr[5:0], 3'b000} +: 8] = PadMarker;
            end
            if (end_ptr <= 7'(LenOffset - 1)) begin
              blk_d[LenBitPos +: 64] = len_field;
            end
            state_d  = StOut;
            ptr_d    = '0;
            ofirst_d = first_q;
            first_d  = 1'b0;
            last_d   = (end_ptr <= 7'(LenOffset - 1));
            ext_d    = (end_ptr > 7'(LenOffset - 1));
            mark_d   = (end_ptr == 7'd64);
          end else begin
            for (int k = 0; k < int'(WORD_BYTES); k++) begin
              blk_d[{ptr_q + 6'(k), 3'b000} +: 8] = in_data[8*k +: 8];
            end
            // Pointer wraps to zero exactly when the block fills
            ptr_d = ptr_q + 6'(WORD_BYTES);
            if (full_blk) begin
              state_d  = StOut;
              last_d   = 1'b0;
              ofirst_d = first_q;
              first_d  = 1'b0;
            end
          end
        end
      end
      StOut: begin
        if (blk_acc) begin
          if (ext_q) begin
            blk_d = '0;
            if (mark_q) begin
              blk_d[0 +: 8] = PadMarker;
            end
            blk_d[LenBitPos +: 64] = len_field;
            last_d   = 1'b1;
            ofirst_d = 1'b0;
            ext_d    = 1'b0;
            mark_d   = 1'b0;
          end else begin
            state_d = StFill;
            if (last_q) begin
              len_d   = '0;
              ptr_d   = '0;
              first_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StFill;
      ptr_q    <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      ext_q    <= 1'b0;
      mark_q   <= 1'b0;
      last_q   <= 1'b0;
      ofirst_q <= 1'b0;
      blk_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      first_q  <= first_d;
      ext_q    <= ext_d;
      mark_q   <= mark_d;
      last_q   <= last_d;
      ofirst_q <= ofirst_d;
      blk_q    <= blk_d;
      run_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md5_stream_padder.sv
// Directed bench for md5_stream_padder: a little-endian and a big-endian instance share
// the same stimulus; each scenario task checks its own expected blocks and flags.
module tb_md5_stream_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_last, out_ready;
  logic [0:31]  in_data;
  logic [2:0]   in_nbytes;
  logic         in_ready, out_valid, out_first, out_last;
  logic [0:511] out_block;
  logic         in_ready_be, out_valid_be, out_first_be, out_last_be;
  logic [0:511] out_block_be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  md5_stream_padder #(
    .WORD_BYTES (4),
    .LEN_LE     (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last)
  );

  md5_stream_padder #(
    .WORD_BYTES (4),
    .LEN_LE     (1'b0)
  ) dut_be (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_be),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .out_valid (out_valid_be),
    .out_ready (out_ready),
    .out_block (out_block_be),
    .out_first (out_first_be),
    .out_last  (out_last_be)
  );

  // Expected block: n data bytes base+i, optional 0x80 at mark_at, optional LE bit length
  function automatic logic [0:511] mk_blk(input int n, input logic [7:0] base,
                                          input int mark_at, input bit with_len,
                                          input logic [63:0] bits);
    logic [0:511] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = base + 8'(i);
    if (mark_at >= 0) r[8*mark_at +: 8] = 8'h80;
    if (with_len) for (int k = 0; k < 8; k++) r[448 + 8*k +: 8] = bits[8*k +: 8];
    return r;
  endfunction

  // Entered and left on a falling edge
  task automatic send_beat(input logic [0:31] d, input logic last, input logic [2:0] nb,
                           output logic ok);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    ok = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: last flag on final data beat; 1: data beats then empty last beat; 2: no last
  task automatic send_msg(input int len, input logic [7:0] base, input int mode,
                          output logic ok);
    int          nbeats;
    logic        okb;
    logic        lastb;
    logic [0:31] d;
    logic [2:0]  nbv;
    ok = 1'b1;
    nbeats = (mode == 0) ? (len + 3) / 4 : len / 4;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < 4; k++) begin
        d[8*k +: 8] = (b*4 + k < len) ? base + 8'(b*4 + k) : 8'hA5;
      end
      lastb = (mode == 0) && (b == nbeats - 1);
      nbv   = lastb ? 3'(len - b*4) : 3'd4;
      send_beat(d, lastb, nbv, okb);
      ok = ok & okb;
    end
    if (mode == 1) begin
      send_beat(32'hDEAD_BEEF, 1'b1, 3'd0, okb);
      ok = ok & okb;
    end
  endtask

  task automatic recv_block(output logic [0:511] blk, output logic [0:511] blk_be,
                            output logic f, output logic l, output logic ok);
    ok = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    blk    = out_block;
    blk_be = out_block_be;
    f      = out_first;
    l      = out_last;
    if (ok) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    n_cmp++;
    if (out_block !== 512'd0) begin
      n_err++; $display("FAIL reset_out_block: got %h want 0", out_block);
    end
    n_cmp++;
    if ({out_first, out_last} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: got %b want 00", {out_first, out_last});
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_abc();
    logic ok, f, l;
    logic [0:511] b, bb, exp_le, exp_be;
    exp_le = {32'h6162_6380, 416'd0, 64'h1800_0000_0000_0000};
    exp_be = {32'h6162_6380, 416'd0, 64'h0000_0000_0000_0018};
    send_msg(3, 8'h61, 0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL abc_send: accepted %b want 1", ok); end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL abc_latency: out_valid %b want 1", out_valid);
    end
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL abc_recv: seen %b want 1", ok); end
    n_cmp++;
    if (b !== exp_le) begin n_err++; $display("FAIL abc_le: got %h want %h", b, exp_le); end
    n_cmp++;
    if (bb !== exp_be) begin n_err++; $display("FAIL abc_be: got %h want %h", bb, exp_be); end
    n_cmp++;
    if ({f, l} !== 2'b11) begin n_err++; $display("FAIL abc_flags: got %b want 11", {f, l}); end
  endtask

  task automatic test_sixty();
    logic ok, f, l;
    logic [0:511] b, bb, e1, e2;
    e1 = mk_blk(60, 8'h00, 60, 1'b0, 64'd0);
    e2 = mk_blk(0, 8'h00, -1, 1'b1, 64'd480);
    send_msg(60, 8'h00, 0, ok);
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e1) begin n_err++; $display("FAIL sixty_b1: got %h want %h", b, e1); end
    n_cmp++;
    if ({f, l} !== 2'b10) begin n_err++; $display("FAIL sixty_b1_flags: got %b want 10", {f, l}); end
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_err++; $display("FAIL sixty_extra_valid: got %b want 10", {out_valid, in_ready});
    end
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e2) begin n_err++; $display("FAIL sixty_b2: got %h want %h", b, e2); end
    n_cmp++;
    if ({f, l} !== 2'b01) begin n_err++; $display("FAIL sixty_b2_flags: got %b want 01", {f, l}); end
  endtask

  task automatic test_full_then_empty();
    logic ok, f, l;
    logic [0:511] b, bb, e1, e2, e3;
    e1 = mk_blk(64, 8'h10, -1, 1'b0, 64'd0);
    e2 = mk_blk(0, 8'h00, 0, 1'b1, 64'd512);
    e3 = mk_blk(0, 8'h00, 0, 1'b1, 64'd0);
    send_msg(64, 8'h10, 2, ok);
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e1) begin n_err++; $display("FAIL full_b1: got %h want %h", b, e1); end
    n_cmp++;
    if ({f, l} !== 2'b10) begin n_err++; $display("FAIL full_b1_flags: got %b want 10", {f, l}); end
    send_beat(32'hDEAD_BEEF, 1'b1, 3'd0, ok);
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e2) begin n_err++; $display("FAIL full_b2: got %h want %h", b, e2); end
    n_cmp++;
    if ({f, l} !== 2'b01) begin n_err++; $display("FAIL full_b2_flags: got %b want 01", {f, l}); end
    send_msg(0, 8'h00, 1, ok);
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e3) begin n_err++; $display("FAIL empty_blk: got %h want %h", b, e3); end
    n_cmp++;
    if ({f, l} !== 2'b11) begin n_err++; $display("FAIL empty_flags: got %b want 11", {f, l}); end
  endtask

  task automatic test_stall();
    logic ok, f, l;
    logic [0:511] b, bb, cap, e1;
    int bad;
    e1 = mk_blk(4, 8'h41, 4, 1'b1, 64'd32);
    send_msg(4, 8'h41, 0, ok);
    cap = out_block;
    in_valid  = 1'b1;
    in_data   = 32'h5A5A_5A5A;
    in_last   = 1'b1;
    in_nbytes = 3'd2;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_block !== cap || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL stall_hold: bad cycles %0d want 0", bad); end
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e1) begin n_err++; $display("FAIL stall_blk: got %h want %h", b, e1); end
    n_cmp++;
    if ({f, l} !== 2'b11) begin n_err++; $display("FAIL stall_flags: got %b want 11", {f, l}); end
  endtask

  task automatic test_back_to_back();
    logic ok, f, l;
    logic [0:511] b, bb, e1, e2;
    e1 = mk_blk(5, 8'h30, 5, 1'b1, 64'd40);
    e2 = mk_blk(3, 8'h61, 3, 1'b1, 64'd24);
    send_msg(5, 8'h30, 0, ok);
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e1) begin n_err++; $display("FAIL b2b_m1: got %h want %h", b, e1); end
    send_msg(3, 8'h61, 0, ok);
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e2) begin n_err++; $display("FAIL b2b_m2: got %h want %h", b, e2); end
    n_cmp++;
    if ({f, l} !== 2'b11) begin n_err++; $display("FAIL b2b_m2_flags: got %b want 11", {f, l}); end
  endtask

  task automatic test_reset_mid();
    logic ok, f, l;
    logic [0:511] b, bb, e1;
    e1 = mk_blk(3, 8'h61, 3, 1'b1, 64'd24);
    send_msg(28, 8'h00, 2, ok);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_fill: got %b want 00", {out_valid, in_ready});
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    send_msg(3, 8'h61, 0, ok);
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e1) begin n_err++; $display("FAIL rstmid_abc: got %h want %h", b, e1); end
    n_cmp++;
    if ({f, l} !== 2'b11) begin n_err++; $display("FAIL rstmid_flags: got %b want 11", {f, l}); end
    // Reset while a block is being offered
    send_msg(3, 8'h61, 0, ok);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rstout_valid: got %b want 0", out_valid);
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    send_msg(3, 8'h61, 0, ok);
    recv_block(b, bb, f, l, ok);
    n_cmp++;
    if (b !== e1 || {f, l} !== 2'b11) begin
      n_err++; $display("FAIL rstout_abc: got %h/%b want %h/11", b, {f, l}, e1);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_nbytes = '0;
    out_ready = 1'b0;
    test_reset();
    test_abc();
    test_sixty();
    test_full_then_empty();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/md5_stream_padder.md
# md5_stream_padder

Streaming, parametrised successor to the single-shot MD5 padding unit. Accepts a message of arbitrary length as a byte-packed word stream with valid/ready handshake. Emits 512-bit padded blocks (data, 0x80 marker, zero fill, 64-bit bit-length) with valid/ready. Sits between the message source and the MD5 (or SHA-family) compression core, flagging first and last blocks of each message.

## Interface
- WORD_BYTES, 4, bytes per input beat; legal values 1, 2, 4, 8.
- LEN_LE, 1, length-field byte order: 1 = little-endian (MD5), 0 = big-endian (SHA-1/SHA-256).
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  [0:8*WORD_BYTES-1]  message bytes; byte k at bits [8k:8k+7].
- in_last  in  1  beat is final beat of message.
- in_nbytes  in  $clog2(WORD_BYTES+1)  valid bytes on last beat, 0..WORD_BYTES; ignored (treated as WORD_BYTES) when in_last=0.
- out_valid  out  1  out_block holds a padded block.
- out_ready  in  1  consumer takes block.
- out_block  out  [0:511]  padded block; byte k at bits [8k:8k+7].
- out_first  out  1  block is first of its message.
- out_last  out  1  block is final of its message.

## Operation
- Handshake: beat transfers when in_valid && in_ready; block transfers when out_valid && out_ready. Once asserted, out_valid and out_block/out_first/out_last hold until transfer.
- State: byte pointer ptr (0..63), 64-bit bit counter len (wraps mod 2^64), 512-bit buffer, first flag, pending-extra flag, pending-marker flag.
- States: FILL (in_ready=1, out_valid=0), OUT (in_ready=0, out_valid=1).
- FILL, non-last beat: write WORD_BYTES bytes at ptr; len += 8*WORD_BYTES; ptr += WORD_BYTES; if ptr reaches 64 → OUT with out_last=0, ptr=0.
- FILL, last beat, n=in_nbytes, e=ptr+n: write n bytes; len += 8n; bytes e..63 zeroed; then:
  - e ≤ 55: byte e=0x80, length in bytes 56..63 → OUT, out_last=1.
  - 56 ≤ e ≤ 63: byte e=0x80, no length → OUT, out_last=0, pending-extra set.
  - e = 64: no marker → OUT, out_last=0, pending-extra and pending-marker set.
- OUT, transfer: if pending-extra → build extra block (all zero, byte 0=0x80 if pending-marker, length in 56..63), stay OUT with out_last=1, out_first=0, clear flags; elif out_last=1 → FILL, clear len/ptr, set first; else → FILL.
- Length field: len (bits) in bytes 56..63; LEN_LE=1 → byte 56 = len[7:0]; LEN_LE=0 → byte 63 = len[7:0].
- out_first=1 only on first emitted block after reset or after a final-block transfer.
- Empty message (in_last, in_nbytes=0 at ptr=0): single block, byte 0=0x80, length 0.
- Non-last beat with in_nbytes ≠ WORD_BYTES: in_nbytes ignored.

## Timing
- Reset (rst low, async): FILL, ptr=0, len=0, first=1, flags clear; out_valid=0, in_ready=0 while rst low, in_ready=1 from first clock after release; out_block=0, out_first=0, out_last=0.
- Latency: out_valid rises the cycle after the beat completing a block (or last beat) is accepted.
- in_ready=0 throughout OUT; one bubble per block minimum; extra block valid the cycle after prior block transfer.
- Reset mid-message or mid-OUT: partial message discarded, no block emitted.

## Structure
- Shared package md5_pkg: block-width constant (512), length-field offset (56), marker byte (8'h80), state enum.
- Sub-module md5_len_field: combinational 64-bit length to 8-byte field with LEN_LE byte-order select; reused by the compression-side length checker.
- Top holds FSM, pointer, counter, byte-lane write enables.

## Test plan
- "abc", WORD_BYTES=4, LEN_LE=1, one beat in_nbytes=3 → one block: bytes 0..3 = 61 62 63 80, bytes 56..63 = 18 00 00 00 00 00 00 00, out_first=out_last=1.
- Same, LEN_LE=0 → bytes 56..63 = 00 00 00 00 00 00 00 18.
- 60-byte message (15 beats) → block 1: byte 60=0x80, bytes 61..63=0, out_last=0; block 2: bytes 0..55=0, bytes 56..57 = E0 01, out_first=0, out_last=1.
- 64-byte message then 0-byte last beat → block 1 raw data, out_last=0; block 2 byte 0=0x80, bytes 56..57 = 00 02 (LE), out_last=1; plus empty message → byte 0=0x80, length 0, out_first=out_last=1.
- out_ready held low 5 cycles during OUT → out_block stable, in_ready=0, no beat accepted; two back-to-back messages → second gets out_first=1, len restarts.
- rst low mid-message (after 7 beats) → out_valid=0 immediately; next "abc" produces the correct single block.
